// File: rtl/reduce_feeder_if.sv
// reduce_feeder_if: host, config, reduce-FIFO, done and bypass signals of the reduce feeder
//  master: environment side (host, config, FIFO status, reduce unit, bypass consumer)
//  slave : feeder side
//  in_flit/in_valid/in_ready          host flit handshake
//  cfg_we/cfg_tag/cfg_children        children-table write port
//  buf_full/fifo_counter              reduce FIFO status
//  wr_en/fifo_data                    reduce FIFO write ({children,flit})
//  done_in/done_tag                   reduction-complete report
//  bypass_flit/bypass_valid/bypass_ready  non-reduce output
//  err_spurious                       sticky done-without-pending error
interface reduce_feeder_if #(
   parameter int PayloadWidth  = 64,
   parameter int ChildrenWidth = 4
);
   localparam int FlitWidth = PayloadWidth + 50;
   logic [FlitWidth-1:0]               in_flit;
   logic                               in_valid;
   logic                               in_ready;
   logic                               cfg_we;
   logic [7:0]                         cfg_tag;
   logic [ChildrenWidth-1:0]           cfg_children;
   logic                               buf_full;
   logic [12:0]                        fifo_counter;
   logic                               wr_en;
   logic [FlitWidth+ChildrenWidth-1:0] fifo_data;
   logic                               done_in;
   logic [7:0]                         done_tag;
   logic [FlitWidth-1:0]               bypass_flit;
   logic                               bypass_valid;
   logic                               bypass_ready;
   logic                               err_spurious;
   modport master (
      output in_flit, in_valid, cfg_we, cfg_tag, cfg_children, buf_full, fifo_counter,
             done_in, done_tag, bypass_ready,
      input  in_ready, wr_en, fifo_data, bypass_flit, bypass_valid, err_spurious
   );
   modport slave (
      input  in_flit, in_valid, cfg_we, cfg_tag, cfg_children, buf_full, fifo_counter,
             done_in, done_tag, bypass_ready,
      output in_ready, wr_en, fifo_data, bypass_flit, bypass_valid, err_spurious
   );
endinterface

// File: rtl/reduce_feeder.sv
// reduce_feeder: stages host flits, tags reduce flits with their children count and writes them to the reduce FIFO
//  clk    rising-edge clock
//  rst_n  asynchronous active-low reset
//  fbus   reduce_feeder_if.slave (host in, config, FIFO write, done, bypass out, error)
module reduce_feeder #(
   parameter int lg_numprocs        = 4,
   parameter int PayloadWidth       = 64,
   parameter int ReductionTableSize = 32,
   parameter int FifoDepth          = 4096,
   parameter int FifoMargin         = 4
) (
   input logic           clk,
   input logic           rst_n,
   reduce_feeder_if.slave fbus
);
   localparam int ChildrenWidth = lg_numprocs;
   localparam int FlitWidth     = PayloadWidth + 50;
   localparam int ValidBit      = FlitWidth - 1;
   localparam int TagPos        = PayloadWidth + 6;
   localparam int IdxW          = $clog2(ReductionTableSize);
   localparam logic [12:0] CountLimit = 13'(FifoDepth - FifoMargin - 1);
   typedef enum logic [1:0] {IDLE, LOOKUP, WAIT, BYPASS} state_e;
   state_e                        state_q, state_d;
   logic [FlitWidth-1:0]          flit_q, flit_d;
   logic [ChildrenWidth-1:0]      children_q, children_d;
   logic [ChildrenWidth-1:0]      table_q [ReductionTableSize];
   logic [ReductionTableSize-1:0] sb_q, sb_d;
   logic                          err_q, err_d;
   logic [IdxW-1:0]               flit_idx, cfg_idx, done_idx;
   logic                          is_reduce, is_bypass, wr;
   logic                          unused_tag_bits;
   // Tags T and T+ReductionTableSize alias onto one scoreboard/table entry
   assign flit_idx        = flit_q[TagPos +: IdxW];
   assign cfg_idx         = fbus.cfg_tag[IdxW-1:0];
   assign done_idx        = fbus.done_tag[IdxW-1:0];
   assign unused_tag_bits = ^{fbus.cfg_tag[7:IdxW], fbus.done_tag[7:IdxW]};
   assign is_reduce = fbus.in_flit[ValidBit] && fbus.in_flit[PayloadWidth+2 +: 2] == 2'b11;
   assign is_bypass = fbus.in_flit[ValidBit] && !is_reduce;
   assign wr = state_q == WAIT && !sb_q[flit_idx] && !fbus.buf_full && fbus.fifo_counter <= CountLimit;
   always_comb begin
      state_d    = state_q;
      flit_d     = flit_q;
      children_d = children_q;
      unique case (state_q)
         IDLE: if (fbus.in_valid) begin
            flit_d  = fbus.in_flit;
            state_d = is_reduce ? LOOKUP : is_bypass ? BYPASS : IDLE;
         end
         LOOKUP: begin
            children_d = table_q[flit_idx];
            state_d    = WAIT;
         end
         WAIT:   state_d = wr ? IDLE : WAIT;
         BYPASS: state_d = fbus.bypass_ready ? IDLE : BYPASS;
      endcase
   end
   // A done and a write on the same entry are exclusive: the write needs the bit clear, the clear needs it set
   always_comb begin
      sb_d  = sb_q;
      err_d = err_q;
      if (fbus.done_in) begin
         if (sb_q[done_idx]) sb_d[done_idx] = 1'b0;
         else err_d = 1'b1;
      end
      if (wr) sb_d[flit_idx] = 1'b1;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         flit_q     <= '0;
         children_q <= '0;
         sb_q       <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         flit_q     <= flit_d;
         children_q <= children_d;
         sb_q       <= sb_d;
         err_q      <= err_d;
      end
   end
   // LOOKUP reads the pre-edge entry, so a same-cycle config write is seen only by later flits
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ReductionTableSize; i++) table_q[i] <= '0;
      end else if (fbus.cfg_we) begin
         table_q[cfg_idx] <= fbus.cfg_children;
      end
   end
   assign fbus.in_ready     = state_q == IDLE;
   assign fbus.wr_en        = wr;
   assign fbus.fifo_data    = {children_q, flit_q};
   assign fbus.bypass_flit  = flit_q;
   assign fbus.bypass_valid = state_q == BYPASS;
   assign fbus.err_spurious = err_q;
endmodule

// File: tb/tb_reduce_feeder.sv
// tb_reduce_feeder: scoreboard bench for reduce_feeder (latency, scoreboard blocking, FIFO gating, bypass, errors, reset)
module tb_reduce_feeder;
   localparam int FW = 114;
   localparam int DW = 118;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int n_cmp = 0;
   int n_mis = 0;
   logic [DW-1:0] exp_q[$];
   logic [FW-1:0] byp_q[$];
   logic [DW-1:0] e;
   logic [FW-1:0] eb;
   reduce_feeder_if #(.PayloadWidth(64), .ChildrenWidth(4)) fbus ();
   reduce_feeder dut (.clk(clk), .rst_n(rst_n), .fbus(fbus));
   always #5 clk = ~clk;
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end
   function automatic logic [FW-1:0] mk_flit(input logic [3:0] op, input logic [7:0] tag,
                                             input logic [63:0] pl, input logic v);
      logic [FW-1:0] f;
      f = '0;
      f[FW-1] = v;
      f[FW-2 -: 8] = 8'hA5;
      f[64 +: 4] = op;
      f[70 +: 8] = tag;
      f[63:0] = pl;
      return f;
   endfunction
   task automatic send(input logic [FW-1:0] f);
      @(negedge clk);
      fbus.in_flit = f;
      fbus.in_valid = 1'b1;
      @(negedge clk);
      fbus.in_valid = 1'b0;
   endtask
   task automatic cfg(input logic [7:0] tag, input logic [3:0] ch);
      @(negedge clk);
      fbus.cfg_we = 1'b1;
      fbus.cfg_tag = tag;
      fbus.cfg_children = ch;
      @(negedge clk);
      fbus.cfg_we = 1'b0;
   endtask
   task automatic done(input logic [7:0] tag);
      @(negedge clk);
      fbus.done_in = 1'b1;
      fbus.done_tag = tag;
      @(negedge clk);
      fbus.done_in = 1'b0;
   endtask
   task automatic test_reset();
      #12;
      n_cmp++; if (fbus.wr_en !== 1'b0) begin n_mis++; $display("FAIL reset_wr_en got %b want 0", fbus.wr_en); end
      n_cmp++; if (fbus.bypass_valid !== 1'b0) begin n_mis++; $display("FAIL reset_bypass_valid got %b want 0", fbus.bypass_valid); end
      n_cmp++; if (fbus.err_spurious !== 1'b0) begin n_mis++; $display("FAIL reset_err got %b want 0", fbus.err_spurious); end
      n_cmp++; if (fbus.fifo_data !== '0) begin n_mis++; $display("FAIL reset_fifo_data got %h want 0", fbus.fifo_data); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++; if (fbus.in_ready !== 1'b1) begin n_mis++; $display("FAIL reset_in_ready got %b want 1", fbus.in_ready); end
   endtask
   task automatic test_basic();
      logic [FW-1:0] f;
      f = mk_flit(4'hC, 8'd5, 64'h40490FDB, 1'b1);
      cfg(8'd5, 4'd3);
      exp_q.push_back({4'd3, f});
      send(f);
      n_cmp++; if (fbus.wr_en !== 1'b0) begin n_mis++; $display("FAIL t1_early_wr got %b want 0", fbus.wr_en); end
      @(negedge clk);
      n_cmp++; if (fbus.wr_en !== 1'b1) begin n_mis++; $display("FAIL t1_wr_en got %b want 1", fbus.wr_en); end
      e = exp_q.pop_front();
      n_cmp++; if (fbus.fifo_data !== e) begin n_mis++; $display("FAIL t1_data got %h want %h", fbus.fifo_data, e); end
      n_cmp++; if (fbus.fifo_data[FW +: 4] !== 4'd3) begin n_mis++; $display("FAIL t1_children got %0d want 3", fbus.fifo_data[FW +: 4]); end
      n_cmp++; if (fbus.fifo_data[63:0] !== 64'h40490FDB) begin n_mis++; $display("FAIL t1_payload got %h want 40490fdb", fbus.fifo_data[63:0]); end
      @(negedge clk);
      n_cmp++; if (fbus.wr_en !== 1'b0) begin n_mis++; $display("FAIL t1_strobe got %b want 0", fbus.wr_en); end
      done(8'd5);
   endtask
   task automatic test_block();
      logic [FW-1:0] fa, fb;
      fa = mk_flit(4'hC, 8'd5, 64'h1111, 1'b1);
      fb = mk_flit(4'hD, 8'd37, 64'h2222, 1'b1);
      exp_q.push_back({4'd3, fa});
      send(fa);
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++; if (fbus.wr_en !== 1'b1 || fbus.fifo_data !== e) begin n_mis++; $display("FAIL t2_first got wr=%b %h want wr=1 %h", fbus.wr_en, fbus.fifo_data, e); end
      send(fb);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_cmp++; if (fbus.wr_en !== 1'b0 || fbus.in_ready !== 1'b0) begin n_mis++; $display("FAIL t2_hold got wr=%b rdy=%b want 0 0", fbus.wr_en, fbus.in_ready); end
      end
      exp_q.push_back({4'd3, fb});
      done(8'd5);
      e = exp_q.pop_front();
      n_cmp++; if (fbus.wr_en !== 1'b1) begin n_mis++; $display("FAIL t2_after_done got %b want 1", fbus.wr_en); end
      n_cmp++; if (fbus.fifo_data !== e) begin n_mis++; $display("FAIL t2_wrap_data got %h want %h", fbus.fifo_data, e); end
      done(8'd37);
      n_cmp++; if (fbus.err_spurious !== 1'b0) begin n_mis++; $display("FAIL t2_wrap_done got err=%b want 0", fbus.err_spurious); end
   endtask
   task automatic test_fifo();
      logic [FW-1:0] f;
      f = mk_flit(4'hF, 8'd5, 64'h3333, 1'b1);
      fbus.fifo_counter = 13'd4092;
      send(f);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_cmp++; if (fbus.wr_en !== 1'b0) begin n_mis++; $display("FAIL t3_margin got %b want 0", fbus.wr_en); end
      end
      exp_q.push_back({4'd3, f});
      fbus.fifo_counter = 13'd4091;
      #1;
      e = exp_q.pop_front();
      n_cmp++; if (fbus.wr_en !== 1'b1 || fbus.fifo_data !== e) begin n_mis++; $display("FAIL t3_limit got wr=%b %h want wr=1 %h", fbus.wr_en, fbus.fifo_data, e); end
      @(negedge clk);
      n_cmp++; if (fbus.wr_en !== 1'b0) begin n_mis++; $display("FAIL t3_strobe got %b want 0", fbus.wr_en); end
      done(8'd5);
      f = mk_flit(4'hC, 8'd6, 64'h4444, 1'b1);
      fbus.fifo_counter = 13'd0;
      fbus.buf_full = 1'b1;
      send(f);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_cmp++; if (fbus.wr_en !== 1'b0) begin n_mis++; $display("FAIL t3_full got %b want 0", fbus.wr_en); end
      end
      exp_q.push_back({4'd0, f});
      fbus.buf_full = 1'b0;
      #1;
      e = exp_q.pop_front();
      n_cmp++; if (fbus.wr_en !== 1'b1 || fbus.fifo_data !== e) begin n_mis++; $display("FAIL t3_leaf got wr=%b %h want wr=1 %h", fbus.wr_en, fbus.fifo_data, e); end
      @(negedge clk);
      done(8'd6);
   endtask
   task automatic test_bypass();
      logic [FW-1:0] f;
      f = mk_flit(4'b0111, 8'd5, 64'h5555, 1'b1);
      fbus.bypass_ready = 1'b0;
      byp_q.push_back(f);
      send(f);
      for (int i = 0; i < 5; i++) begin
         n_cmp++; if (fbus.bypass_valid !== 1'b1 || fbus.wr_en !== 1'b0) begin n_mis++; $display("FAIL t4_hold got bv=%b wr=%b want 1 0", fbus.bypass_valid, fbus.wr_en); end
         @(negedge clk);
      end
      eb = byp_q.pop_front();
      n_cmp++; if (fbus.bypass_flit !== eb) begin n_mis++; $display("FAIL t4_flit got %h want %h", fbus.bypass_flit, eb); end
      fbus.bypass_ready = 1'b1;
      @(negedge clk);
      n_cmp++; if (fbus.bypass_valid !== 1'b0 || fbus.in_ready !== 1'b1) begin n_mis++; $display("FAIL t4_release got bv=%b rdy=%b want 0 1", fbus.bypass_valid, fbus.in_ready); end
      send(mk_flit(4'hC, 8'd5, 64'h6666, 1'b0));
      n_cmp++; if (fbus.in_ready !== 1'b1 || fbus.bypass_valid !== 1'b0) begin n_mis++; $display("FAIL t4_discard got rdy=%b bv=%b want 1 0", fbus.in_ready, fbus.bypass_valid); end
      @(negedge clk);
      n_cmp++; if (fbus.wr_en !== 1'b0) begin n_mis++; $display("FAIL t4_discard_wr got %b want 0", fbus.wr_en); end
   endtask
   task automatic test_spurious();
      n_cmp++; if (fbus.err_spurious !== 1'b0) begin n_mis++; $display("FAIL t5_pre got %b want 0", fbus.err_spurious); end
      done(8'd9);
      for (int i = 0; i < 3; i++) begin
         n_cmp++; if (fbus.err_spurious !== 1'b1) begin n_mis++; $display("FAIL t5_sticky got %b want 1", fbus.err_spurious); end
         @(negedge clk);
      end
   endtask
   task automatic test_reset_mid();
      logic [FW-1:0] f;
      f = mk_flit(4'hC, 8'd5, 64'h7777, 1'b1);
      exp_q.push_back({4'd3, f});
      send(f);
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++; if (fbus.wr_en !== 1'b1 || fbus.fifo_data !== e) begin n_mis++; $display("FAIL t6_pre got wr=%b %h want wr=1 %h", fbus.wr_en, fbus.fifo_data, e); end
      send(mk_flit(4'hC, 8'd5, 64'h8888, 1'b1));
      @(negedge clk);
      n_cmp++; if (fbus.wr_en !== 1'b0 || fbus.in_ready !== 1'b0) begin n_mis++; $display("FAIL t6_wait got wr=%b rdy=%b want 0 0", fbus.wr_en, fbus.in_ready); end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (fbus.err_spurious !== 1'b0 || fbus.wr_en !== 1'b0 || fbus.bypass_valid !== 1'b0) begin n_mis++; $display("FAIL t6_async got err=%b wr=%b bv=%b want 0 0 0", fbus.err_spurious, fbus.wr_en, fbus.bypass_valid); end
      n_cmp++; if (fbus.fifo_data !== '0 || fbus.in_ready !== 1'b1) begin n_mis++; $display("FAIL t6_state got %h rdy=%b want 0 rdy=1", fbus.fifo_data, fbus.in_ready); end
      @(negedge clk);
      rst_n = 1'b1;
      f = mk_flit(4'hC, 8'd5, 64'h9999, 1'b1);
      exp_q.push_back({4'd0, f});
      send(f);
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++; if (fbus.wr_en !== 1'b1 || fbus.fifo_data !== e) begin n_mis++; $display("FAIL t6_after got wr=%b %h want wr=1 %h", fbus.wr_en, fbus.fifo_data, e); end
   endtask
   initial begin
      fbus.in_flit = '0;
      fbus.in_valid = 1'b0;
      fbus.cfg_we = 1'b0;
      fbus.cfg_tag = '0;
      fbus.cfg_children = '0;
      fbus.buf_full = 1'b0;
      fbus.fifo_counter = '0;
      fbus.done_in = 1'b0;
      fbus.done_tag = '0;
      fbus.bypass_ready = 1'b1;
      test_reset();
      test_basic();
      test_block();
      test_fifo();
      test_bypass();
      test_spurious();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
